// File: rtl/dram_arb_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
package dram_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  localparam logic CORE = 1'b0;
  localparam logic HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/dram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a contest goes to
// whichever requester was not granted last.
module rr_pick2
  import dram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant_id,
  output logic       grant_any
);

  // Pick the winner from the valid pattern and the previous grant.
  always_comb begin
    grant_any = |valid;
    case (valid)
      2'b01:   grant_id = CORE;
      2'b10:   grant_id = HOST;
      2'b11:   grant_id = ~last;
      default: grant_id = CORE;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the processor core and the host loader onto one single-port
// data memory. One access in flight at a time; reads take an extra cycle to
// capture the synchronous memory output.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_grant
);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              grant_id;
  logic              grant_any;
  logic              lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  rr_pick2 u_pick (
    .valid     ({req1_valid, req0_valid}),
    .last      (last_grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and accept decision; accept is only possible in IDLE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE:   next_state = lat_we ? RESP : CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the winning request so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= HOST;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (accept) begin
      last_grant <= grant_id;
      lat_id     <= grant_id;
      lat_we     <= (grant_id == HOST) ? req1_we    : req0_we;
      lat_addr   <= (grant_id == HOST) ? req1_addr  : req0_addr;
      lat_wdata  <= (grant_id == HOST) ? req1_wdata : req0_wdata;
    end
  end

  // Capture read data into the owning requester's holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else if (state == CAPTURE) begin
      if (lat_id == HOST) begin
        rsp1_rdata <= mem_rdata;
      end else begin
        rsp0_rdata <= mem_rdata;
      end
    end
  end

  // Strobes decoded from state, all forced low while reset is asserted.
  always_comb begin
    req0_ready = accept && (grant_id == CORE) && !rst;
    req1_ready = accept && (grant_id == HOST) && !rst;
    mem_en     = (state == ISSUE) && !rst;
    mem_we     = (state == ISSUE) && lat_we && !rst;
    rsp0_valid = (state == RESP) && (lat_id == CORE) && !rst;
    rsp1_valid = (state == RESP) && (lat_id == HOST) && !rst;
    busy       = (state != IDLE) && !rst;
    mem_addr   = lat_addr;
    mem_wdata  = lat_wdata;
  end

endmodule
